// File: rtl/edge_output_streamer.sv
// Edge-pixel transmitter: buffers hysteresis output in a small FIFO and
// re-emits it as a framed raster stream with SOF/EOL/EOF markers.
module edge_output_streamer #(
  parameter int Image_Width  = 512,
  parameter int Image_Height = 512,
  parameter int FIFO_Depth   = 16
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       start_frame,
  input  logic [7:0] in_pixel,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_pixel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sof,
  output logic       out_eol,
  output logic       out_eof,
  output logic       busy,
  output logic       frame_done
);

  localparam int PIX = Image_Width * Image_Height;
  localparam int ICW = $clog2(PIX + 1);
  localparam int CW  = $clog2(Image_Width);
  localparam int RW  = (Image_Height > 1) ? $clog2(Image_Height) : 1;
  localparam int AW  = $clog2(FIFO_Depth);
  localparam int OW  = AW + 1;

  localparam logic [CW-1:0]  COL_LAST = CW'(Image_Width - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(Image_Height - 1);
  localparam logic [ICW-1:0] PIX_MAX  = ICW'(PIX);
  localparam logic [OW-1:0]  OCC_MAX  = OW'(FIFO_Depth);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0]     mem [FIFO_Depth];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [OW-1:0]  occ;
  logic [ICW-1:0] in_count;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic clear;
  logic at_eol;
  logic at_eof;
  logic at_sof;

  assign full  = (occ == OCC_MAX);
  assign empty = (occ == '0);
  assign clear = (state_q == IDLE) && start_frame;

  assign in_ready  = (state_q == STREAM) && !full
                   && (in_count < PIX_MAX);
  assign out_valid = (state_q == STREAM) && !empty;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign at_sof = (row == '0) && (col == '0);
  assign at_eol = (col == COL_LAST);
  assign at_eof = at_eol && (row == ROW_LAST);

  assign out_pixel = out_valid ? mem[rd_ptr] : '0;
  assign out_sof   = out_valid && at_sof;
  assign out_eol   = out_valid && at_eol;
  assign out_eof   = out_valid && at_eof;

  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_frame) state_d = STREAM;
      STREAM:  if (pop && at_eof) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      in_count <= '0;
    end else if (clear) begin
      in_count <= '0;
    end else if (push) begin
      in_count <= in_count + ICW'(1);
    end
  end

  // Raster position follows the output side only, so markers
  // stay frozen on the head pixel under backpressure.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (pop) begin
      if (at_eol) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: doc/edge_output_streamer.md
# edge_output_streamer

Output-side transmitter for the edge detector: accepts finished edge pixels from the hysteresis stage through a valid/ready push port and buffers them in a small FIFO. It re-emits them as a framed raster stream (start-of-frame, end-of-line, end-of-frame markers) over a valid/ready output port, so a downstream consumer can apply backpressure. It is the transmit counterpart of the pixel-input path of `edge_detection_top` and sits between the hysteresis stage and the top-level output pins.

## Interface
- `Image_Width`, 512, pixels per line (≥2)
- `Image_Height`, 512, lines per frame (≥1)
- `FIFO_Depth`, 16, buffer entries; power of two, ≥2
- `clk`  in  1  single system clock, all logic on rising edge
- `rstN`  in  1  asynchronous, active-low reset
- `start_frame`  in  1  one-cycle request to begin a frame; honoured only in IDLE
- `in_pixel`  in  8  edge pixel from hysteresis stage
- `in_valid`  in  1  `in_pixel` valid
- `in_ready`  out  1  streamer can accept `in_pixel` this cycle
- `out_pixel`  out  8  pixel to downstream
- `out_valid`  out  1  `out_pixel` and markers valid
- `out_ready`  in  1  downstream accepts this cycle
- `out_sof`  out  1  current output pixel is row 0, column 0
- `out_eol`  out  1  current output pixel is column `Image_Width-1`
- `out_eof`  out  1  current output pixel is the last pixel of the frame
- `busy`  out  1  state ≠ IDLE
- `frame_done`  out  1  one-cycle pulse after the last output transfer

## Operation
- States:
  - IDLE: `start_frame`=1 → STREAM. Counters and FIFO pointers are cleared on entry.
  - STREAM: the last output transfer (the one with `out_eof`=1) → DONE.
  - DONE: unconditional → IDLE.
- Input transfer occurs when `in_valid && in_ready`. `in_ready` = (state==STREAM) && !full && (in_count < W·H). It is a function of registered state only, never of `in_valid`.
- Output transfer occurs when `out_valid && out_ready`. `out_valid` = (state==STREAM) && !empty. `out_pixel` is the FIFO head (show-ahead). The head and the markers hold stable while `out_valid`=1 and `out_ready`=0.
- Counters, all width `$clog2` of range:
  - `in_count` counts 0..W·H and increments on input transfer.
  - `col` counts 0..W-1 and `row` counts 0..H-1. Both advance on output transfer only. `col` wraps to 0 at W-1 and `row` increments on that wrap.
- Markers are combinational from `col`/`row`, gated by `out_valid`:
  - `out_sof` = (row==0 && col==0)
  - `out_eol` = (col==W-1)
  - `out_eof` = `out_eol` && (row==H-1)
- Simultaneous push and pop: both occur and occupancy is unchanged. Push is gated by the registered `full`, so a pop in the same cycle does not open a slot until the next cycle.
- Pixels after the W·H-th are refused (`in_ready`=0) until the next frame. No data is dropped or duplicated.
- `start_frame` in STREAM or DONE is ignored.
- Reset mid-frame aborts the frame: FIFO is emptied, counters are cleared, and the block returns to IDLE. No `frame_done` is generated.
- Pixel values pass through unmodified. No arithmetic is performed on data.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_pixel`=0, `out_sof`/`out_eol`/`out_eof`=0, `busy`=0, `frame_done`=0.
- `start_frame` sampled at edge N → `busy`=1 and `in_ready`=1 after edge N (cycle N+1).
- Latency is 1 cycle: a pixel accepted at edge N into an empty FIFO shows `out_valid`=1 after edge N. There is no combinational input-to-output bypass.
- Sustained throughput is 1 pixel/cycle when `in_valid`=`out_ready`=1 continuously.
- The last output transfer at edge M → DONE in cycle M+1 with `frame_done`=1 and `busy`=1. IDLE in cycle M+2 with `busy`=0.
- Full FIFO: `in_ready`=0 in the cycle after the FIFO_Depth-th unpopped push.

## Test plan
Use W=4, H=2, FIFO_Depth=4 for all tests.
- Reset and idle:
  - Assert `rstN`=0 → all outputs 0.
  - Release, hold `in_valid`=1 without `start_frame` → `in_ready` stays 0 and nothing is emitted.
- Full-rate frame:
  - Stimulus: `start_frame`, then pixels 0x10..0x17 with `in_valid`=`out_ready`=1.
  - Response: outputs 0x10..0x17 in order, one per cycle. `out_sof` on 0x10, `out_eol` on 0x13 and 0x17, `out_eof` on 0x17 only, `frame_done` one cycle later, then `busy`=0.
- Backpressure:
  - Stimulus: `out_ready`=0 while 4 pixels are pushed.
  - Response: `in_ready`=0 after the 4th push, and `out_pixel`=first pixel held stable.
  - Release `out_ready` → all 8 pixels are delivered with no loss or duplication.
- Overrun guard: offer 10 pixels in one frame → only 8 accepted. `in_ready`=0 after the 8th accept, until the next `start_frame`.
- Mid-frame events:
  - `start_frame` during STREAM → ignored, and marker positions are unchanged.
  - `rstN` pulsed after 3 outputs → IDLE, FIFO empty, and no `frame_done`.
  - A new frame after that reset starts with `out_sof` on its first pixel.
- Random handshakes: random `in_valid`/`out_ready` over 3 back-to-back frames → output sequence equals input sequence. Each frame has exactly 1 `out_sof`, 2 `out_eol`, and 1 `out_eof`.
